// File: rtl/l2_flush_ctrl_pkg.sv
// Shared types and constants for the L2 flush controller.
package l2_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned FLUSH_ALL_MAX_BITS = 128;
  localparam logic [FLUSH_ALL_MAX_BITS-1:0] FLUSH_ALL = '1;

  localparam int unsigned WDOG_CNT_BITS = 32;

endpackage

// File: rtl/l2_flush_ctrl_if.sv
// Requester and L2 flush-port signals of the flush controller.
interface l2_flush_ctrl_if #(
  parameter int unsigned NREQ      = 5,
  parameter int unsigned ADDR_BITS = 48
);
  logic [NREQ-1:0]           i_req_valid;
  logic [NREQ*ADDR_BITS-1:0] i_req_addr;
  logic [NREQ-1:0]           o_req_ready;
  logic [NREQ-1:0]           o_resp_valid;
  logic [NREQ-1:0]           o_resp_err;
  logic                      o_flush_valid;
  logic [ADDR_BITS-1:0]      o_flush_address;
  logic                      i_flush_end;
  logic                      o_busy;

  modport master (
    output i_req_valid, i_req_addr, i_flush_end,
    input  o_req_ready, o_resp_valid, o_resp_err, o_flush_valid, o_flush_address, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_flush_end,
    output o_req_ready, o_resp_valid, o_resp_err, o_flush_valid, o_flush_address, o_busy
  );
endinterface

// File: rtl/l2_flush_rr_arb.sv
// Combinational round-robin pick: first pending slot above rr_ptr, wrapping.
module l2_flush_rr_arb #(
  parameter int unsigned NREQ  = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int unsigned slot;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = |pending;
    slot      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      slot = int'(rr_ptr) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      if (pending[IDX_W'(slot)] && (grant_oh == '0)) begin
        grant_oh[IDX_W'(slot)] = 1'b1;
        grant_idx              = IDX_W'(slot);
      end
    end
  end

endmodule

// File: rtl/l2_flush_ctrl.sv
// L2 flush sequencer: round-robin grant, coalescing of identical requests, one flush in flight.
// Optional watchdog in WAIT when L2_FLUSH_TIMEOUT_EN is defined.
module l2_flush_ctrl
  import l2_flush_ctrl_pkg::*;
#(
  parameter int unsigned NREQ           = 5,
  parameter int unsigned ADDR_BITS      = 48,
  parameter int unsigned LINE_BITS      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic            i_clk,
  input logic            i_rst,
  l2_flush_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_BITS-1:0] ALL_ONES  = FLUSH_ALL[ADDR_BITS-1:0];
  localparam logic [ADDR_BITS-1:0] LINE_MASK = {{(ADDR_BITS-LINE_BITS){1'b1}}, {LINE_BITS{1'b0}}};

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t               state_q, state_d;
  logic [NREQ-1:0]      pending_q, mask_q, accept, match, resp_clr, grant_oh;
  logic [ADDR_BITS-1:0] addr_q   [NREQ];
  logic [ADDR_BITS-1:0] req_norm [NREQ];
  logic [ADDR_BITS-1:0] flush_addr_q, sel_addr;
  logic [IDX_W-1:0]     rr_ptr_q, grant_q, grant_idx;
  logic                 grant_any, timeout_hit;

  l2_flush_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept   = bus.i_req_valid & ~pending_q;
  assign resp_clr = (state_q == RESP) ? mask_q : '0;

  always_comb begin
    sel_addr = '0;
    match    = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      req_norm[n] = bus.i_req_addr[n*ADDR_BITS +: ADDR_BITS];
      if (req_norm[n] != ALL_ONES) req_norm[n] = req_norm[n] & LINE_MASK;
      if (grant_oh[n]) sel_addr = addr_q[n];
      match[n] = pending_q[n] && (addr_q[n] == flush_addr_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.i_flush_end || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Coalesce mask is captured in ISSUE from the current pending set, so
  // requests accepted on or after the ISSUE edge wait for a later flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q    <= '0;
      mask_q       <= '0;
      flush_addr_q <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      for (int unsigned n = 0; n < NREQ; n++) addr_q[n] <= '0;
    end else begin
      pending_q <= (pending_q & ~resp_clr) | accept;
      for (int unsigned n = 0; n < NREQ; n++) begin
        if (accept[n]) addr_q[n] <= req_norm[n];
      end
      if (state_q == IDLE && grant_any) begin
        flush_addr_q <= sel_addr;
        grant_q      <= grant_idx;
      end
      if (state_q == ISSUE) mask_q   <= match;
      if (state_q == RESP)  rr_ptr_q <= grant_q;
    end
  end

`ifdef L2_FLUSH_TIMEOUT_EN
  logic [WDOG_CNT_BITS-1:0] wdog_q;
  logic                     timed_out_q;

  // Counter holds k-1 in the k-th WAIT cycle; firing one step early means
  // the transition happens on the edge where it would reach TIMEOUT_CYCLES-1.
  localparam logic [WDOG_CNT_BITS-1:0] WDOG_LAST = WDOG_CNT_BITS'(TIMEOUT_CYCLES - 2);

  assign timeout_hit = (state_q == WAIT) && !bus.i_flush_end && (wdog_q == WDOG_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
    end else if (state_q == WAIT) begin
      wdog_q <= wdog_q + 1'b1;
      if (timeout_hit) timed_out_q <= 1'b1;
    end
  end

  assign bus.o_resp_err = timed_out_q ? resp_clr : '0;
`else
  assign timeout_hit    = 1'b0;
  assign bus.o_resp_err = '0;
`endif

  assign bus.o_req_ready     = ~pending_q;
  assign bus.o_resp_valid    = resp_clr;
  assign bus.o_flush_valid   = (state_q == ISSUE);
  assign bus.o_flush_address = flush_addr_q;
  assign bus.o_busy          = (state_q != IDLE) || (|pending_q);

endmodule
